// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

  // Bit counter width: it has to hold WIDTH-1 (WIDTH >= 2 keeps this >= 1).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready and shifts it
// out one bit per clock, with back-to-back frames and no idle gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ser_out_nxt, ser_valid_nxt, frame_start_nxt;
  logic             accept;

  // A new word may land on the same edge that retires the last bit of the old one.
  assign din_ready = reset && ((state == IDLE) || (cnt == '0));
  assign accept    = din_valid && din_ready;
  assign busy      = ser_valid;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt       = state;
    shreg_nxt       = shreg;
    cnt_nxt         = cnt;
    ser_out_nxt     = ser_out;
    ser_valid_nxt   = ser_valid;
    frame_start_nxt = 1'b0;

    if (accept) begin
      state_nxt       = SHIFT;
      cnt_nxt         = LAST_CNT;
      ser_valid_nxt   = 1'b1;
      frame_start_nxt = 1'b1;
      if (MSB_FIRST) begin
        ser_out_nxt = din[WIDTH-1];
        shreg_nxt   = din << 1;
      end else begin
        ser_out_nxt = din[0];
        shreg_nxt   = din >> 1;
      end
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - CW'(1);
        if (MSB_FIRST) begin
          ser_out_nxt = shreg[WIDTH-1];
          shreg_nxt   = shreg << 1;
        end else begin
          ser_out_nxt = shreg[0];
          shreg_nxt   = shreg >> 1;
        end
      end else begin
        state_nxt     = IDLE;
        ser_out_nxt   = IDLE_LEVEL;
        ser_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      ser_out     <= IDLE_LEVEL;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      cnt         <= cnt_nxt;
      ser_out     <= ser_out_nxt;
      ser_valid   <= ser_valid_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances checked every cycle against
// a queue model of the bits each frame should put on the line.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;

  logic rdy_m, so_m, sv_m, fs_m, busy_m;
  logic rdy_l, so_l, sv_l, fs_l, busy_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m),
    .frame_start(fs_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l),
    .frame_start(fs_l), .busy(busy_l)
  );

  // Model: each queue holds the bits still to appear, head = bit on the line now.
  typedef struct {
    bit b;
    bit s;
  } slot_t;

  slot_t q_m[$];
  slot_t q_l[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          last_acc;
  logic [31:0] cap_m, cap_l;
  int          n_valid, n_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_cap();
    cap_m   = '0;
    cap_l   = '0;
    n_valid = 0;
    n_fs    = 0;
  endtask

  task automatic check_one(input string name, input slot_t q[$], input logic rdy,
                           input logic so, input logic sv, input logic fs, input logic bz);
    bit exp_v, exp_o, exp_s;
    exp_v = q.size() > 0;
    exp_o = 1'b0;
    exp_s = 1'b0;
    if (exp_v) begin
      exp_o = q[0].b;
      exp_s = q[0].s;
    end
    check({name, " ser_valid"}, sv, exp_v);
    check({name, " ser_out"}, so, exp_o);
    check({name, " frame_start"}, fs, exp_s);
    check({name, " busy"}, bz, exp_v);
    check({name, " din_ready"}, rdy, reset && (q.size() <= 1));
  endtask

  task automatic check_outputs();
    check_one("msb", q_m, rdy_m, so_m, sv_m, fs_m, busy_m);
    check_one("lsb", q_l, rdy_l, so_l, sv_l, fs_l, busy_l);
    if (sv_m === 1'b1) begin
      cap_m = {cap_m[30:0], so_m};
      n_valid++;
      if (fs_m === 1'b1) n_fs++;
    end
    if (sv_l === 1'b1) cap_l = {24'h0, so_l, cap_l[7:1]};
  endtask

  task automatic model_edge();
    bit acc;
    acc = reset && din_valid && (q_m.size() <= 1);
    if (reset) begin
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          q_m.push_back('{din[7-i], i == 0});
          q_l.push_back('{din[i], i == 0});
        end
      end
    end
    last_acc = acc;
  endtask

  // One clock: check outputs mid-cycle, drive inputs, update the model on the edge.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    check_outputs();
    reset     = r;
    din_valid = v;
    din       = d;
    if (!r) begin
      q_m.delete();
      q_l.delete();
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_m.size() > 0 || q_l.size() > 0) && n < 40) begin
      cycle(1'b1, 1'b0, 8'h00);
      n++;
    end
    check("drain timeout", n < 40, 1'b1);
    cycle(1'b1, 1'b0, 8'h00);
  endtask

  // Drive din with valid held until the model says it was taken; returns tries used.
  task automatic send(input logic [7:0] d, output int tries);
    tries = 0;
    do begin
      cycle(1'b1, 1'b1, d);
      tries++;
    end while (!last_acc && tries < 40);
    check("send timeout", last_acc, 1'b1);
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    check_outputs();
    #2;
    reset = 1'b0;
    #1;
    q_m.delete();
    q_l.delete();
    check("async msb ser_valid", sv_m, 1'b0);
    check("async lsb ser_valid", sv_l, 1'b0);
    check("async msb din_ready", rdy_m, 1'b0);
    check("async msb ser_out", so_m, 1'b0);
    @(posedge clk);
    model_edge();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    int tries;

    // Reset held with din_valid high: nothing may be accepted.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hA5);
    cycle(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("ready after release", rdy_m, 1'b1);

    // Single word A5.
    clear_cap();
    send(8'hA5, tries);
    check("single accept tries", tries, 1);
    drain();
    check("single msb bits", cap_m[7:0], 8'hA5);
    check("single lsb bits", cap_l[7:0], 8'hA5);
    check("single valid cycles", n_valid, 8);
    check("single frame starts", n_fs, 1);

    // Back-to-back A5 then 3C with valid held.
    clear_cap();
    send(8'hA5, tries);
    send(8'h3C, tries);
    check("b2b second tries", tries, 8);
    drain();
    check("b2b msb bits", cap_m[15:0], 16'hA53C);
    check("b2b valid cycles", n_valid, 16);
    check("b2b frame starts", n_fs, 2);

    // FF presented during an all-zero frame is held off until the last bit.
    clear_cap();
    send(8'h00, tries);
    send(8'hFF, tries);
    check("ignore ff tries", tries, 8);
    drain();
    check("ignore msb bits", cap_m[15:0], 16'h00FF);

    // Reset during bit 4 of F0, then a clean 81 frame.
    send(8'hF0, tries);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
    async_reset_pulse();
    clear_cap();
    send(8'h81, tries);
    check("post reset tries", tries, 1);
    drain();
    check("post reset msb bits", cap_m[7:0], 8'h81);
    check("post reset valid", n_valid, 8);

    // LSB-first instance with 01: first bit 1, then seven 0s.
    clear_cap();
    send(8'h01, tries);
    drain();
    check("lsb 01 bits", cap_l[7:0], 8'h01);
    check("msb 01 bits", cap_m[7:0], 8'h01);

    // Random traffic with occasional mid-frame resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) begin
        async_reset_pulse();
      end else begin
        cycle(1'b1, $urandom_range(99) < 70, 8'($urandom));
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter: the sending end for serial links consumed by the team's serial-in shift-register receivers.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on ser_out.
- Marks each frame with ser_valid and a one-cycle frame_start pulse.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.
- IDLE_LEVEL, 0: value driven on ser_out when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- din  input  WIDTH  parallel word to send.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept din this cycle.
- ser_out  output  1  serial data bit, registered.
- ser_valid  output  1  ser_out carries a frame bit, registered.
- frame_start  output  1  high during the first bit of each frame, registered.
- busy  output  1  a frame is in progress; equals ser_valid.

Behaviour:
- Reset (reset=0, takes effect immediately without a clock edge):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_out=IDLE_LEVEL, ser_valid=0, frame_start=0, busy=0.
  - din_ready=0 while reset is low.
- States: IDLE and SHIFT.
- Transfer occurs on a rising edge where din_valid=1 and din_ready=1 ("accept").
- din_ready is combinational: 1 in IDLE; 1 in SHIFT only when the bit counter is 0 (last bit on the line); otherwise 0.
- Accept in IDLE:
  - On the accepting edge, ser_out is loaded with the first bit.
  - ser_valid=1, frame_start=1, counter=WIDTH-1.
  - The remaining WIDTH-1 bits are held in the shift register; state moves to SHIFT.
  - The first bit is visible in the cycle immediately after the accepting edge.
- SHIFT, counter>0: each edge drives the next bit onto ser_out, decrements the counter, and sets frame_start=0.
- SHIFT, counter=0 (last bit on the line):
  - With accept: load the new word exactly as in IDLE. frame_start=1 again and there is no gap cycle, so steady-state throughput is one word per WIDTH cycles.
  - Without accept: return to IDLE with ser_out=IDLE_LEVEL, ser_valid=0.
- Bit order: MSB_FIRST=1 shifts left and takes the MSB; MSB_FIRST=0 shifts right and takes the LSB.
- din is sampled only on the accepting edge. Changes to din or din_valid while din_ready=0 are ignored and have no effect on the frame in progress.
- Each frame is exactly WIDTH consecutive ser_valid cycles.
- The counter width is clog2(WIDTH). The counter never wraps below 0.
- Reset asserted mid-frame: the frame is aborted immediately and the partial word is discarded. After release, the block is in IDLE with din_ready=1 on the first cycle.
- No X propagation: all registers are reset.

Decomposition:
- Shared package piso_pkg:
  - state enum (IDLE, SHIFT).
  - Constant function for counter width, clog2(WIDTH).
  - Default IDLE_LEVEL constant.
- No sub-module: counter, shift register and FSM fit in one module of roughly 150 lines.

Test Plan:
1. Reset check: hold reset=0 for 3 cycles with din_valid=1 -> din_ready=0, ser_out=0, ser_valid=0, frame_start=0 throughout. Release -> din_ready=1 next cycle.
2. Single word, MSB_FIRST=1: din=8'hA5 accepted once -> ser_out=1,0,1,0,0,1,0,1 over 8 cycles, ser_valid=1 for exactly 8 cycles, frame_start=1 only on the first. Then ser_out=0 and ser_valid=0.
3. Back-to-back: hold din_valid=1; present 8'hA5, then 8'h3C when din_ready rises -> 16 contiguous ser_valid cycles, bits 10100101 00111100, frame_start high on cycles 1 and 9.
4. Ignored input: change din to 8'hFF with din_valid=1 during bits 2-7 of an 8'h00 frame -> serial stream stays all zeros; 8'hFF is accepted only on the last-bit cycle.
5. Mid-frame reset: assert reset=0 between clock edges during bit 4 of 8'hF0 -> ser_valid drops to 0 without waiting for an edge. After release, send 8'h81 -> clean frame 10000001.
6. LSB_FIRST instance (MSB_FIRST=0): send 8'h01 -> ser_out=1 then seven 0s.
